// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : Moore FSM sequencing the shared multicycle RV32I datapath
// Rev 1.0
// ============================================================================
module multicycle_control #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcWrite,
  output logic               pcSrc,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               regWrite,
  output logic               memToReg,
  output logic [1:0]         aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [3:0]         aluCtrl,
  output logic               halt,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_MEM_RD = 4'd3;
  localparam logic [3:0] S_WB_MEM = 4'd4;
  localparam logic [3:0] S_MEM_WR = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_EXEC_I = 4'd7;
  localparam logic [3:0] S_WB_ALU = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_TRAP   = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = 1'b0;
    iorD     = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    irWrite  = 1'b0;
    regWrite = 1'b0;
    memToReg = 1'b0;
    aluSrcA  = SRCA_PC;
    aluSrcB  = SRCB_RS2;
    aluCtrl  = ALU_ADD;
    halt     = 1'b0;

    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        if (mem_ready) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end
      end

      // Speculatively forms the branch target so BRANCH can reuse the ALU for the compare.
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end

      S_ADDR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        if (opcode == OP_LOAD) begin
          state_d = S_MEM_RD;
        end else if (opcode == OP_STORE) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_TRAP;
        end
      end

      S_MEM_RD: begin
        iorD    = 1'b1;
        memRead = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end
      end

      S_WB_MEM: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEM_WR: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXEC_R: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        state_d = S_WB_ALU;
        case ({funct7, funct3})
          10'b0000000_000: aluCtrl = ALU_ADD;
          10'b0100000_000: aluCtrl = ALU_SUB;
          10'b0000000_111: aluCtrl = ALU_AND;
          10'b0000000_110: aluCtrl = ALU_OR;
          default:         state_d = S_TRAP;
        endcase
      end

      S_EXEC_I: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        state_d = S_WB_ALU;
        case (funct3)
          3'b000:  aluCtrl = ALU_ADD;
          3'b111:  aluCtrl = ALU_AND;
          3'b110:  aluCtrl = ALU_OR;
          default: state_d = S_TRAP;
        endcase
      end

      S_WB_ALU: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_BRANCH: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        aluCtrl = ALU_SUB;
        pcSrc   = 1'b1;
        case (funct3)
          3'b000: begin
            pcWrite = zero;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          3'b001: begin
            pcWrite = ~zero;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end

      S_TRAP: begin
        halt = 1'b1;
      end

      default: state_d = S_TRAP;
    endcase

    // Reset silences every strobe immediately, even in the middle of a memory access.
    if (reset) begin
      retire   = 1'b0;
      pcWrite  = 1'b0;
      pcSrc    = 1'b0;
      iorD     = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      irWrite  = 1'b0;
      regWrite = 1'b0;
      memToReg = 1'b0;
      aluSrcA  = SRCA_PC;
      aluSrcB  = SRCB_RS2;
      aluCtrl  = ALU_ADD;
      halt     = 1'b0;
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = STATE_W'(state_q);
  assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control : instruction-level random bench for multicycle_control
// Rev 1.0
// ============================================================================
module tb_multicycle_control;

  // Narrow counter so the wrap-around is reachable in a short run.
  localparam int TB_CNT_W = 10;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_ADDR = 4'd2, S_MEM_RD = 4'd3,
                         S_WB_MEM = 4'd4, S_MEM_WR = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
                         S_WB_ALU = 4'd8, S_BRANCH = 4'd9, S_TRAP = 4'd10;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_B = 7'b1100011, OP_BAD = 7'b1111111;

  typedef struct packed {
    logic       pcw, pcs, iord, mrd, mwr, irw, rgw, m2r;
    logic [1:0] sa, sb;
    logic [3:0] alu;
    logic       halt;
  } outs_t;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic pcWrite, pcSrc, iorD, memRead, memWrite, irWrite, regWrite, memToReg, halt;
  logic [1:0] aluSrcA, aluSrcB;
  logic [3:0] aluCtrl, state;
  logic [TB_CNT_W-1:0] instret;

  multicycle_control #(.STATE_W(4), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .pcWrite(pcWrite), .pcSrc(pcSrc), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite),
    .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluCtrl(aluCtrl),
    .halt(halt), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_count = 0;
  outs_t exp_o;
  logic [3:0] exp_st;
  logic [TB_CNT_W-1:0] exp_inst;
  logic [TB_CNT_W-1:0] model_cnt = '0;
  logic exp_valid = 1'b0, chk_state = 1'b0, chk_inst = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      outs_t act;
      act = {pcWrite, pcSrc, iorD, memRead, memWrite, irWrite, regWrite, memToReg,
             aluSrcA, aluSrcB, aluCtrl, halt};
      check($sformatf("outs@st%0d", exp_st), 32'(act), 32'(exp_o));
      if (chk_state) check("state", 32'(state), 32'(exp_st));
      if (chk_inst)  check("instret", 32'(instret), 32'(exp_inst));
    end
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.alu = 4'b0010;
    return o;
  endfunction

  // {legal, aluCtrl} for an R-type funct7/funct3 pair
  function automatic logic [4:0] r_ctrl(input logic [6:0] f7, input logic [2:0] f3);
    if (f7 == 7'b0000000 && f3 == 3'b000) return 5'b1_0010;
    if (f7 == 7'b0100000 && f3 == 3'b000) return 5'b1_0110;
    if (f7 == 7'b0000000 && f3 == 3'b111) return 5'b1_0000;
    if (f7 == 7'b0000000 && f3 == 3'b110) return 5'b1_0001;
    return 5'b0_0010;
  endfunction

  function automatic logic [4:0] i_ctrl(input logic [2:0] f3);
    if (f3 == 3'b000) return 5'b1_0010;
    if (f3 == 3'b111) return 5'b1_0000;
    if (f3 == 3'b110) return 5'b1_0001;
    return 5'b0_0010;
  endfunction

  // One clock cycle: publish expectations and inputs, let the compare process sample, step.
  task automatic cyc(input outs_t o, input logic [3:0] st, input logic mr, input logic z,
                     input logic ret);
    exp_o = o; exp_st = st; exp_inst = model_cnt;
    mem_ready = mr; zero = z; exp_valid = 1'b1;
    cyc_count++;
    @(posedge clk); #1;
    if (ret) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; chk_state = 1'b0; chk_inst = 1'b0;
    cyc(base(), S_FETCH, rb(), rb(), 1'b0);
    model_cnt = '0; chk_state = 1'b1; chk_inst = 1'b1;
    cyc(base(), S_FETCH, rb(), rb(), 1'b0);
    reset = 1'b0;
  endtask

  task automatic fetch_decode(input int fw);
    outs_t o;
    o = base(); o.mrd = 1; o.sb = 2'b01;
    for (int i = 0; i < fw; i++) cyc(o, S_FETCH, 1'b0, rb(), 1'b0);
    o.irw = 1; o.pcw = 1;
    cyc(o, S_FETCH, 1'b1, rb(), 1'b0);
    o = base(); o.sa = 2'b01; o.sb = 2'b10;
    cyc(o, S_DECODE, rb(), rb(), 1'b0);
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input int fw, input int mw, input logic z, output logic trapped);
    outs_t o;
    logic [4:0] rc;
    logic leg;
    trapped = 1'b0;
    opcode = op; funct3 = f3; funct7 = f7;
    fetch_decode(fw);
    case (op)
      OP_LOAD, OP_STORE: begin
        o = base(); o.sa = 2'b10; o.sb = 2'b10;
        cyc(o, S_ADDR, rb(), rb(), 1'b0);
        o = base(); o.iord = 1;
        if (op == OP_LOAD) begin
          o.mrd = 1;
          for (int i = 0; i < mw; i++) cyc(o, S_MEM_RD, 1'b0, rb(), 1'b0);
          cyc(o, S_MEM_RD, 1'b1, rb(), 1'b0);
          o = base(); o.rgw = 1; o.m2r = 1;
          cyc(o, S_WB_MEM, rb(), rb(), 1'b1);
        end else begin
          o.mwr = 1;
          for (int i = 0; i < mw; i++) cyc(o, S_MEM_WR, 1'b0, rb(), 1'b0);
          cyc(o, S_MEM_WR, 1'b1, rb(), 1'b1);
        end
      end
      OP_R, OP_I: begin
        rc = (op == OP_R) ? r_ctrl(f7, f3) : i_ctrl(f3);
        o = base(); o.sa = 2'b10; o.sb = (op == OP_R) ? 2'b00 : 2'b10; o.alu = rc[3:0];
        cyc(o, (op == OP_R) ? S_EXEC_R : S_EXEC_I, rb(), rb(), 1'b0);
        if (rc[4]) begin
          o = base(); o.rgw = 1;
          cyc(o, S_WB_ALU, rb(), rb(), 1'b1);
        end else trapped = 1'b1;
      end
      OP_B: begin
        leg = (f3 == 3'b000) || (f3 == 3'b001);
        o = base(); o.sa = 2'b10; o.alu = 4'b0110; o.pcs = 1;
        o.pcw = leg && ((f3 == 3'b000) ? z : !z);
        cyc(o, S_BRANCH, rb(), z, leg);
        trapped = !leg;
      end
      default: trapped = 1'b1;
    endcase
    if (trapped) begin
      o = base(); o.halt = 1;
      for (int i = 0; i < 10; i++) cyc(o, S_TRAP, rb(), rb(), 1'b0);
    end
  endtask

  initial begin
    int c0, k, fw, mw, idx;
    logic tr, z;
    logic [6:0] op, f7;
    logic [2:0] f3;
    outs_t o;
    logic [9:0] rtab [4];
    logic [2:0] itab [3];
    rtab[0] = 10'b0000000_000; rtab[1] = 10'b0100000_000;
    rtab[2] = 10'b0000000_111; rtab[3] = 10'b0000000_110;
    itab[0] = 3'b000; itab[1] = 3'b111; itab[2] = 3'b110;

    reset = 1'b1; zero = 1'b0; mem_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;
    @(posedge clk); #1;
    do_reset();

    c0 = cyc_count;
    instr(OP_R, 3'b000, 7'b0000000, 0, 0, 1'b0, tr);
    check("add_cycles", 32'(cyc_count - c0), 32'd4);
    check("add_instret", 32'(instret), 32'd1);

    c0 = cyc_count;
    instr(OP_LOAD, 3'b010, 7'b0000000, 0, 3, 1'b0, tr);
    check("lw_wait_cycles", 32'(cyc_count - c0), 32'd8);
    check("lw_instret", 32'(instret), 32'd2);

    instr(OP_B, 3'b000, 7'd0, 0, 0, 1'b1, tr);
    instr(OP_B, 3'b001, 7'd0, 0, 0, 1'b1, tr);
    check("branch_instret", 32'(instret), 32'd4);

    opcode = OP_STORE; funct3 = 3'b010;
    fetch_decode(0);
    o = base(); o.sa = 2'b10; o.sb = 2'b10;
    cyc(o, S_ADDR, rb(), rb(), 1'b0);
    o = base(); o.iord = 1; o.mwr = 1;
    cyc(o, S_MEM_WR, 1'b0, rb(), 1'b0);
    cyc(o, S_MEM_WR, 1'b0, rb(), 1'b0);
    do_reset();
    check("reset_mid_store_instret", 32'(instret), 32'd0);

    instr(OP_I, 3'b000, 7'd0, 1, 0, 1'b0, tr);
    instr(OP_BAD, 3'b000, 7'd0, 0, 0, 1'b0, tr);
    check("illegal_op_halt", 32'(halt), 32'd1);
    check("illegal_op_instret", 32'(instret), 32'd1);
    do_reset();
    check("halt_cleared", 32'(halt), 32'd0);
    instr(OP_R, 3'b000, 7'b0000001, 0, 0, 1'b0, tr);
    check("bad_funct7_halt", 32'(halt), 32'd1);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 99);
      fw = $urandom_range(0, 2); mw = $urandom_range(0, 3); z = rb();
      f3 = 3'($urandom); f7 = 7'($urandom);
      if (k < 15) op = OP_LOAD;
      else if (k < 30) op = OP_STORE;
      else if (k < 50) begin
        op = OP_R;
        if ($urandom_range(0, 9) < 8) begin
          idx = $urandom_range(0, 3);
          {f7, f3} = rtab[idx];
        end
      end else if (k < 70) begin
        op = OP_I;
        if ($urandom_range(0, 9) < 8) f3 = itab[$urandom_range(0, 2)];
      end else if (k < 92) begin
        op = OP_B;
        if ($urandom_range(0, 9) < 9) f3 = 3'($urandom_range(0, 1));
      end else op = 7'($urandom);
      instr(op, f3, f7, fw, mw, z, tr);
      if (tr) do_reset();
    end

    while (model_cnt != '1) instr(OP_B, 3'($urandom_range(0, 1)), 7'd0, 0, 0, rb(), tr);
    check("instret_all_ones", 32'(instret), 32'(10'h3FF));
    instr(OP_STORE, 3'b010, 7'd0, 0, 1, 1'b0, tr);
    check("instret_wrap", 32'(instret), 32'd0);

    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
